debounce_3ch: RTL and testbench
===============================

Name: debounce_3ch

Overview:
- Input conditioner for three raw mechanical switch or button lines.
- Per channel: a 2-flop synchronizer, then a debounce FSM with a down-counter.
- Outputs are clean registered levels plus single-cycle rising-edge ticks.
- Sits directly upstream of the 3-input AND stage: db[0], db[1] and db[2] drive its a, b and c inputs.

Parameters:
- N, 19: debounce counter width. A level must be stable for 2^N clock cycles before it is accepted (about 5.2 ms at 100 MHz).

Ports:
- clk, input, 1: system clock. All state is updated on the rising edge.
- reset, input, 1: asynchronous, active-high reset. Clears all state immediately.
- sw, input, 3: raw asynchronous switch inputs, one bit per channel.
- db, output, 3: debounced levels, registered; bit i feeds AND-stage input i.
- tick, output, 3: one-cycle pulse per channel when db[i] rises from 0 to 1, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - sync flops = 0; FSM state = ZERO; counter = 0; db = 3'b000; tick = 3'b000.
  - Reset asserted mid-count aborts the count. Outputs drop to 0 in the same cycle, without waiting for a clock edge.
- Synchronizer: s1[i] <= sw[i]; s2[i] <= s1[i]. Only s2 drives the FSM.
- FSM per channel: states ZERO, WAIT1, ONE, WAIT0.
  - ZERO:
    - s2=1 -> WAIT1, load q = 2^N-1.
    - else stay.
  - WAIT1:
    - s2=0 -> ZERO (glitch rejected, db stays 0).
    - s2=1 and q!=0 -> q <= q-1.
    - s2=1 and q==0 -> ONE, assert tick for exactly one cycle.
  - ONE:
    - s2=0 -> WAIT0, load q = 2^N-1.
    - else stay.
  - WAIT0:
    - s2=1 -> ONE (glitch rejected, db stays 1, no tick).
    - s2=0 and q!=0 -> q <= q-1.
    - s2=0 and q==0 -> ZERO.
- db[i] is registered: it equals 1 in states ONE and WAIT0, 0 in ZERO and WAIT1. It has no combinational path from sw.
- Latency, sw[i] rising before edge 1 and held stable:
  - edge 1: s1 captures.
  - edge 2: s2 captures.
  - edge 3: state = WAIT1.
  - edge 3+2^N: state = ONE; db[i]=1 and tick[i]=1 during the following cycle.
  - The falling direction is symmetric: db[i]=0 after edge 3+2^N, with no tick.
- Any pulse or gap shorter than 2^N cycles at s2 causes no change on db.
- Channels are fully independent. Simultaneous transitions on several channels are each handled in the same cycle; a tick on one channel never affects another.
- Counter width is exactly N bits. Decrement never wraps, because q==0 always exits the WAIT state.
- An unreachable state encoding returns to ZERO on the next edge.

Decomposition:
- Shared package/include:
  - state encodings ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11;
  - the default N.
- Sub-module debounce_ch: one channel, containing the synchronizer, FSM, counter, db and tick. Ports: clk, reset, sw_i, db_o, tick_o; parameter N.
- Top debounce_3ch instantiates debounce_ch three times with a generate loop.

Test Plan (N=3, so 2^N=8):
- Reset check: assert reset with sw=3'b111 mid-count (state WAIT1) -> db=3'b000 and tick=3'b000 immediately, before the next edge. After release, with sw held at 111, db=111 11 edges later.
- Clean press: sw=3'b001 held from before edge 1 -> db=3'b001 and tick=3'b001 in the cycle after edge 11. tick returns to 000 after edge 12.
- Bounce rejection: sw[1] toggles 1,0,1,0 every 3 cycles, then settles at 1 -> no tick until 8 consecutive stable cycles at s2. Exactly one tick[1] pulse and one db[1] rising edge.
- Release with glitch: from db=3'b111, sw[2] drops to 0 for 5 cycles then returns to 1 -> db stays 111 with no tick. Holding sw[2]=0 -> db=3'b011 after 11 edges, with no tick.
- Simultaneous channels: sw goes 000 -> 111 in a single cycle -> all three db bits rise after the same edge, and tick=3'b111 for exactly one cycle.
- Downstream integration: drive the AND stage from db -> its output y=1 only after all three channels are debounced high. y falls 11 edges after any single sw bit is held at 0.

Source files
------------

// File: rtl/debounce_3ch_pkg.sv
// -----------------------------------------------------------------------------
// debounce_3ch_pkg
// Shared definitions for the three-channel switch debouncer.
//   DB_N_DEFAULT : default debounce counter width. A level must be stable for
//                  2^N clock cycles before it is accepted.
//   db_state_e   : per-channel debounce FSM state encoding.
// -----------------------------------------------------------------------------
package debounce_3ch_pkg;

    localparam int DB_N_DEFAULT = 19;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,  // accepted level 0, input agrees
        ST_WAIT1 = 2'b01,  // accepted level 0, input has gone high, counting
        ST_ONE   = 2'b10,  // accepted level 1, input agrees
        ST_WAIT0 = 2'b11   // accepted level 1, input has gone low, counting
    } db_state_e;

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounce channel: 2-flop synchronizer, four-state debounce FSM with an
// N-bit down-counter, registered debounced level and registered rising tick.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset, clears all state immediately
//   sw_i   : raw asynchronous switch input
//   db_o   : debounced level (registered, no combinational path from sw_i)
//   tick_o : one-cycle pulse in the cycle where db_o first reads 1
//
// Handshake: none. db_o/tick_o are plain registered levels/pulses sampled by
// the consumer on any clock edge; there is no valid/ready backpressure.
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce_3ch_pkg::*;
#(
    parameter int N = DB_N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic db_o,
    output logic tick_o
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    db_state_e     state_q, state_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          tick_q, tick_d;

    always_comb begin
        s1_d    = sw_i;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_ZERO: begin
                if (s2_q) begin
                    state_d = ST_WAIT1;
                    cnt_d   = CNT_MAX;
                end
            end
            ST_WAIT1: begin
                if (!s2_q) begin
                    state_d = ST_ZERO;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_ONE;
                    tick_d  = 1'b1;
                end
            end
            ST_ONE: begin
                if (!s2_q) begin
                    state_d = ST_WAIT0;
                    cnt_d   = CNT_MAX;
                end
            end
            ST_WAIT0: begin
                if (s2_q) begin
                    state_d = ST_ONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_ZERO;
                end
            end
            default: begin
                // Unreachable encoding: recover to the idle-low state.
                state_d = ST_ZERO;
            end
        endcase

        // db is registered from the next state so it lines up with the state
        // register: high exactly while the FSM sits in ONE or WAIT0.
        db_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            tick_q  <= tick_d;
        end
    end

    assign db_o   = db_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/debounce_3ch.sv
// -----------------------------------------------------------------------------
// debounce_3ch
// Three independent switch debouncers. db[0..2] feed the a/b/c inputs of the
// downstream 3-input AND stage.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   sw[2:0]    : raw asynchronous switch inputs, one bit per channel
//   db[2:0]    : debounced registered levels
//   tick[2:0]  : one-cycle registered pulse per channel on a 0->1 of db
// -----------------------------------------------------------------------------
module debounce_3ch
    import debounce_3ch_pkg::*;
#(
    parameter int N = DB_N_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    output logic [2:0] db,
    output logic [2:0] tick
);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        debounce_ch #(
            .N (N)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .sw_i   (sw[i]),
            .db_o   (db[i]),
            .tick_o (tick[i])
        );
    end

endmodule

// File: tb/tb_debounce_3ch.sv
// -----------------------------------------------------------------------------
// tb_debounce_3ch
// Bench for debounce_3ch with N=3 (2^N = 8). Directed steps followed by a
// random phase; every cycle is compared against a run-length reference model:
// a channel's accepted level flips once the synchronized input has disagreed
// with it on 2^N+1 consecutive clock edges.
// -----------------------------------------------------------------------------
module tb_debounce_3ch;

    localparam int N    = 3;
    localparam int FLIP = (1 << N) + 1;

    logic       clk;
    logic       reset;
    logic [2:0] sw;
    logic [2:0] db;
    logic [2:0] tick;
    logic       y;

    int total = 0;
    int bad   = 0;

    debounce_3ch #(
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .tick  (tick)
    );

    // Downstream 3-input AND stage fed by db[0], db[1], db[2].
    assign y = db[0] & db[1] & db[2];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] m_s1, m_s2, m_db, m_tick;
    int         m_run [3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1   <= 3'b000;
            m_s2   <= 3'b000;
            m_db   <= 3'b000;
            m_tick <= 3'b000;
            for (int c = 0; c < 3; c++) m_run[c] <= 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (m_s2[c] != m_db[c]) begin
                    if (m_run[c] + 1 == FLIP) begin
                        m_db[c]   <= m_s2[c];
                        m_tick[c] <= m_s2[c];
                        m_run[c]  <= 0;
                    end else begin
                        m_run[c]  <= m_run[c] + 1;
                        m_tick[c] <= 1'b0;
                    end
                end else begin
                    m_run[c]  <= 0;
                    m_tick[c] <= 1'b0;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= sw;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare against the model on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("model_db", db, m_db);
        chk("model_tick", tick, m_tick);
    endtask

    int ticks1;
    int rises1;
    logic prev_db1;

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        sw    = 3'b000;
        #1;
        chk("reset_db", db, 3'b000);
        chk("reset_tick", tick, 3'b000);
        step();
        step();
        reset = 1'b0;

        // Clean press on channel 0.
        sw = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("press_db_wait", db, 3'b000);
        end
        step();
        chk("press_db", db, 3'b001);
        chk("press_tick", tick, 3'b001);
        step();
        chk("press_tick_end", tick, 3'b000);
        chk("press_db_hold", db, 3'b001);

        // Asynchronous reset mid-count, then simultaneous rise on all channels.
        sw = 3'b111;
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_db", db, 3'b000);
        chk("async_reset_tick", tick, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("simul_db_wait", db, 3'b000);
        end
        step();
        chk("simul_db", db, 3'b111);
        chk("simul_tick", tick, 3'b111);
        chk("and_y_high", {2'b00, y}, 3'b001);
        step();
        chk("simul_tick_end", tick, 3'b000);

        // Release glitch on channel 2 shorter than the debounce window.
        sw = 3'b011;
        repeat (5) step();
        sw = 3'b111;
        for (int k = 0; k < 15; k++) begin
            step();
            chk("glitch_db", db, 3'b111);
            chk("glitch_tick", tick, 3'b000);
        end

        // Held release on channel 2; AND output falls with it.
        sw = 3'b011;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("release_db_wait", db, 3'b111);
            chk("release_y_wait", {2'b00, y}, 3'b001);
        end
        step();
        chk("release_db", db, 3'b011);
        chk("release_tick", tick, 3'b000);
        chk("release_y", {2'b00, y}, 3'b000);

        // Drop channel 1 cleanly so it can be bounced back up.
        sw = 3'b001;
        repeat (11) step();
        chk("drop_ch1_db", db, 3'b001);

        // Bounce on channel 1: 1,0,1,0 for 3 cycles each, then settle at 1.
        ticks1   = 0;
        rises1   = 0;
        prev_db1 = db[1];
        for (int ph = 0; ph < 4; ph++) begin
            sw[1] = (ph % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("bounce_db", db, 3'b001);
                if (tick[1]) ticks1++;
                if (db[1] && !prev_db1) rises1++;
                prev_db1 = db[1];
            end
        end
        sw[1] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 10) chk("bounce_settle_wait", db, 3'b001);
            if (k == 11) begin
                chk("bounce_settle_db", db, 3'b011);
                chk("bounce_settle_tick", tick, 3'b010);
            end
            if (tick[1]) ticks1++;
            if (db[1] && !prev_db1) rises1++;
            prev_db1 = db[1];
        end
        chk("bounce_tick_count", 3'(ticks1), 3'd1);
        chk("bounce_rise_count", 3'(rises1), 3'd1);

        // AND stage rises only once every channel is debounced high.
        sw = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("and_y_wait", {2'b00, y}, 3'b000);
        end
        step();
        chk("and_y_rise", {2'b00, y}, 3'b001);
        chk("and_tick", tick, 3'b100);

        // Random phase: sparse toggles give a mix of short and long runs,
        // with an occasional asynchronous reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rand_async_reset", db | tick, 3'b000);
                @(negedge clk);
                reset = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
